// File: rtl/ofm_pool_upsample_stage.sv
// rtl/ofm_pool_upsample_stage.sv - bypass / 2x2 maxpool s1,s2 / 2x upsample row stage
// Optional leaky ReLU on input lanes when OFM_POOL_LEAKY_RELU_EN is defined.
module ofm_pool_upsample_stage #(
  parameter int SYSTOLIC_SIZE = 16,
  parameter int DATA_WIDTH    = 16,
  parameter int ROW_W         = 9
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [1:0]                          mode,
  input  logic [ROW_W-1:0]                    tile_rows,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [SYSTOLIC_SIZE*DATA_WIDTH-1:0] in_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [SYSTOLIC_SIZE*DATA_WIDTH-1:0] out_data,
  output logic [$clog2(SYSTOLIC_SIZE):0]      out_lanes,
  output logic                                out_last,
  output logic                                busy
);
  localparam int S  = SYSTOLIC_SIZE;
  localparam int W  = DATA_WIDTH;
  localparam int VW = S * W;
  localparam int LW = $clog2(S) + 1;

  localparam logic [1:0] MODE_BYPASS = 2'd0;
  localparam logic [1:0] MODE_POOL1  = 2'd1;
  localparam logic [1:0] MODE_POOL2  = 2'd2;
  localparam logic [1:0] MODE_UP     = 2'd3;

  localparam logic [LW-1:0] LANES_FULL = LW'(S);
  localparam logic [LW-1:0] LANES_HALF = LW'(S / 2);

  function automatic logic [VW-1:0] relu(input logic [VW-1:0] v);
    logic [VW-1:0] r;
    r = v;
`ifdef OFM_POOL_LEAKY_RELU_EN
    for (int i = 0; i < S; i++)
      if (v[i*W+W-1]) r[i*W +: W] = $signed(v[i*W +: W]) >>> 3;
`endif
    return r;
  endfunction

  function automatic logic [VW-1:0] vmax(input logic [VW-1:0] a, input logic [VW-1:0] b);
    logic [VW-1:0] r;
    r = a;
    for (int i = 0; i < S; i++)
      if ($signed(b[i*W +: W]) > $signed(a[i*W +: W])) r[i*W +: W] = b[i*W +: W];
    return r;
  endfunction

  // Rightmost lane has no right neighbour, so it replicates itself.
  function automatic logic [VW-1:0] hmax(input logic [VW-1:0] v);
    logic [VW-1:0] r;
    r = v;
    for (int i = 0; i < S - 1; i++)
      if ($signed(v[(i+1)*W +: W]) > $signed(v[i*W +: W])) r[i*W +: W] = v[(i+1)*W +: W];
    return r;
  endfunction

  function automatic logic [VW-1:0] decim(input logic [VW-1:0] v);
    logic [VW-1:0] r;
    r = '0;
    for (int j = 0; j < S / 2; j++) r[j*W +: W] = v[2*j*W +: W];
    return r;
  endfunction

  function automatic logic [VW-1:0] upsel(input logic [VW-1:0] v, input logic hi);
    logic [VW-1:0] r;
    for (int k = 0; k < S; k++) r[k*W +: W] = v[((hi ? S / 2 : 0) + k / 2)*W +: W];
    return r;
  endfunction

  logic [VW-1:0]    prev;
  logic [ROW_W-1:0] row;
  logic [ROW_W-1:0] rows_q;
  logic [1:0]       mode_q;
  logic [1:0]       pend;
  logic             pend_last;

  logic [VW-1:0]    cur;
  logic [1:0]       eff_mode;
  logic [ROW_W-1:0] eff_rows;
  logic [ROW_W-1:0] t_eff;
  logic             cur_last;
  logic             in_fire;
  logic             out_fire;

  assign in_ready = (pend == 2'd0) && (!out_valid || out_ready);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign cur      = relu(in_data);
  assign eff_mode = (row == '0) ? mode : mode_q;
  assign eff_rows = (row == '0) ? tile_rows : rows_q;
  assign t_eff    = (eff_rows == '0) ? ROW_W'(1) : eff_rows;
  assign cur_last = (row == t_eff - ROW_W'(1));

  logic          emit;
  logic [VW-1:0] emit_data;
  logic [LW-1:0] emit_lanes;
  logic [1:0]    emit_pend;
  logic          emit_last;
  logic [VW-1:0] pend_data;

  always_comb begin
    emit       = 1'b1;
    emit_data  = cur;
    emit_lanes = LANES_FULL;
    emit_pend  = 2'd0;
    case (eff_mode)
      MODE_POOL1: begin
        emit      = (row != '0) || cur_last;
        emit_data = hmax((row == '0) ? cur : vmax(prev, cur));
        emit_pend = (cur_last && row != '0) ? 2'd1 : 2'd0;
      end
      MODE_POOL2: begin
        emit       = row[0] || cur_last;
        emit_data  = decim(hmax(row[0] ? vmax(prev, cur) : cur));
        emit_lanes = LANES_HALF;
      end
      MODE_UP: begin
        emit_data = upsel(cur, 1'b0);
        emit_pend = 2'd3;
      end
      default: ;
    endcase
    emit_last = cur_last && (emit_pend == 2'd0);
  end

  // Extra beats replay the stored row: H(row) for pool1, HI/LO/HI for upsample.
  assign pend_data = (mode_q == MODE_UP) ? upsel(prev, pend[0]) : hmax(prev);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_lanes <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      prev      <= '0;
      row       <= '0;
      rows_q    <= '0;
      mode_q    <= MODE_BYPASS;
      pend      <= 2'd0;
      pend_last <= 1'b0;
    end else begin
      if (in_fire) begin
        prev      <= cur;
        row       <= cur_last ? '0 : row + ROW_W'(1);
        pend      <= emit_pend;
        pend_last <= cur_last;
        out_valid <= emit;
        if (row == '0) begin
          mode_q <= mode;
          rows_q <= tile_rows;
        end
        if (emit) begin
          out_data  <= emit_data;
          out_lanes <= emit_lanes;
          out_last  <= emit_last;
        end
      end else if (out_fire) begin
        if (pend != 2'd0) begin
          out_data <= pend_data;
          out_last <= (pend == 2'd1) && pend_last;
          pend     <= pend - 2'd1;
        end else begin
          out_valid <= 1'b0;
        end
      end
      if (in_fire && row == '0) busy <= 1'b1;
      else if (out_fire && out_last) busy <= 1'b0;
    end
  end
endmodule
